// File: rtl/iq_dequant_if.sv
// Coefficient stream bundle for iq_dequant: block control, input stream and
// dequantized output stream. The slave modport is the dequantizer's view;
// the master modport is the producer/consumer environment around it.
interface iq_dequant_if #(
    parameter int unsigned IN_W  = 12,
    parameter int unsigned OUT_W = 12
);
    logic                    start;
    logic                    busy;
    logic                    in_valid;
    logic signed [IN_W-1:0]  in_coef;
    logic                    out_valid;
    logic signed [OUT_W-1:0] out_coef;
    logic [5:0]              out_idx;
    logic                    blk_done;

    modport master (
        output start, in_valid, in_coef,
        input  busy, out_valid, out_coef, out_idx, blk_done
    );

    modport slave (
        input  start, in_valid, in_coef,
        output busy, out_valid, out_coef, out_idx, blk_done
    );
endinterface

// File: rtl/iq_dequant.sv
// iq_dequant: inverse quantization of a 64-coefficient block. Each accepted
// coefficient is paired with its factor from the registered romq table and
// multiplied; the result leaves two cycles after the accept, tagged with its
// index. Define IQ_SAT_EN to saturate the product to OUT_W bits instead of
// keeping the low OUT_W bits (two's-complement wrap).
module iq_dequant #(
    parameter int unsigned IN_W  = 12,
    parameter int unsigned Q_W   = 8,
    parameter int unsigned OUT_W = 12
) (
    input  logic           clk,
    input  logic           rst,
    iq_dequant_if.slave    bus,
    output logic [5:0]     rom_a,
    input  logic [Q_W-1:0] rom_d
);
    localparam int unsigned IDX_W  = 6;
    localparam int unsigned PROD_W = IN_W + Q_W + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = '1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                   state;
    state_t                   state_nxt;
    logic [IDX_W-1:0]         idx;
    logic [IDX_W-1:0]         idx_nxt;
    logic                     accept_c;

    logic                     s1_valid;
    logic signed [IN_W-1:0]   s1_coef;
    logic [IDX_W-1:0]         s1_idx;

    logic signed [PROD_W-1:0] prod_c;
    logic signed [OUT_W-1:0]  red_c;

    // Block sequencing: start opens a block, the accept of index 63 closes it
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        accept_c  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nxt = RUN;
                    idx_nxt   = '0;
                end
            end
            RUN: begin
                if (bus.in_valid) begin
                    accept_c = 1'b1;
                    idx_nxt  = idx + IDX_W'(1);
                    if (idx == LAST_IDX) begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                idx_nxt   = '0;
            end
        endcase
    end

    // FSM state and index counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    // romq is addressed by the live counter; its registered output lines up with stage 1
    assign rom_a    = idx;
    assign bus.busy = (state == RUN);

    // Stage 1: hold the accepted coefficient and its index while romq reads
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_coef  <= '0;
            s1_idx   <= '0;
        end else begin
            s1_valid <= accept_c;
            if (accept_c) begin
                s1_coef <= bus.in_coef;
                s1_idx  <= idx;
            end
        end
    end

    // Signed coefficient times zero-extended factor, full precision
    always_comb begin
        prod_c = PROD_W'(s1_coef) * PROD_W'($signed({1'b0, rom_d}));
    end

`ifdef IQ_SAT_EN
    // Clamp to the OUT_W signed range when the upper product bits are not a sign extension
    always_comb begin
        red_c = prod_c[OUT_W-1:0];
        if ((|prod_c[PROD_W-1:OUT_W-1]) && !(&prod_c[PROD_W-1:OUT_W-1])) begin
            red_c = prod_c[PROD_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                     : {1'b0, {(OUT_W-1){1'b1}}};
        end
    end
`else
    // Keep the low OUT_W bits of the product
    always_comb begin
        red_c = prod_c[OUT_W-1:0];
    end
`endif

    // Stage 2: registered result, index tag and strobes
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out_valid <= 1'b0;
            bus.out_coef  <= '0;
            bus.out_idx   <= '0;
            bus.blk_done  <= 1'b0;
        end else begin
            bus.out_valid <= s1_valid;
            bus.blk_done  <= s1_valid && (s1_idx == LAST_IDX);
            if (s1_valid) begin
                bus.out_coef <= red_c;
                bus.out_idx  <= s1_idx;
            end
        end
    end
endmodule

// File: tb/tb_iq_dequant.sv
// Directed bench for iq_dequant with a registered romq model. Expected values
// come from a hand-computed vector table and simple closed-form blocks.
module tb_iq_dequant;
    localparam int unsigned IN_W  = 12;
    localparam int unsigned Q_W   = 8;
    localparam int unsigned OUT_W = 12;
    localparam int          N_TAB = 14;

    typedef struct {
        int coef;
        int q;
        int exp_wrap;
        int exp_sat;
    } vec_t;

    logic           clk = 1'b0;
    logic           rst;
    logic [5:0]     rom_a;
    logic [Q_W-1:0] rom_d;
    logic [Q_W-1:0] rom_tab [64];

    iq_dequant_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

    iq_dequant #(.IN_W(IN_W), .Q_W(Q_W), .OUT_W(OUT_W)) dut (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus),
        .rom_a (rom_a),
        .rom_d (rom_d)
    );

    always #5 clk = ~clk;

    // romq model: one registered cycle of read latency
    always @(posedge clk) rom_d <= rom_tab[rom_a];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;
    int stim [64];
    int exp_coef [128];
    int cap_coef [$];
    int cap_idx [$];
    int cap_done [$];
    int cap_cyc [$];
    int drv_cyc [$];
    int stray_done = 0;
    vec_t vt [N_TAB];

    // Output monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (bus.out_valid === 1'b1) begin
            cap_coef.push_back(int'(bus.out_coef));
            cap_idx.push_back(int'(bus.out_idx));
            cap_done.push_back(int'(bus.blk_done));
            cap_cyc.push_back(cyc);
        end else if (bus.blk_done === 1'b1) begin
            stray_done++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    task automatic check(input string name, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_caps();
        cap_coef.delete();
        cap_idx.delete();
        cap_done.delete();
        cap_cyc.delete();
        drv_cyc.delete();
        stray_done = 0;
    endtask

    // Start a block and stream n coefficients from stim[], with gap idle cycles between
    task automatic run_block(input int gap, input int n);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int i = 0; i < n; i++) begin
            bus.in_valid = 1'b1;
            bus.in_coef  = 12'(stim[i]);
            drv_cyc.push_back(cyc);
            step();
            bus.in_valid = 1'b0;
            for (int g = 0; g < gap; g++) step();
        end
    endtask

    task automatic check_stream(input string tag, input int n);
        check($sformatf("%s count", tag), cap_idx.size(), n);
        for (int i = 0; i < n && i < cap_idx.size(); i++) begin
            check($sformatf("%s idx[%0d]", tag, i), cap_idx[i], i % 64);
            check($sformatf("%s coef[%0d]", tag, i), cap_coef[i], exp_coef[i]);
            check($sformatf("%s done[%0d]", tag, i), cap_done[i], int'((i % 64) == 63));
            if (i < drv_cyc.size())
                check($sformatf("%s latency[%0d]", tag, i), cap_cyc[i] - drv_cyc[i], 2);
        end
        check($sformatf("%s stray_done", tag), stray_done, 0);
    endtask

    function automatic int vec_exp(input vec_t v);
`ifdef IQ_SAT_EN
        return v.exp_sat;
`else
        return v.exp_wrap;
`endif
    endfunction

    task automatic load_ramp(input int mult, input int base);
        for (int i = 0; i < 64; i++) begin
            stim[i]           = mult;
            rom_tab[i]        = 8'(i + 1);
            exp_coef[base + i] = mult * (i + 1);
        end
    endtask

    initial begin
        //            coef   q    wrap   sat
        vt[0]  = '{    2,   1,     2,     2};
        vt[1]  = '{   -3,   5,   -15,   -15};
        vt[2]  = '{  100,  20,  2000,  2000};
        vt[3]  = '{ 2047,  99,  1949,  2047};
        vt[4]  = '{-2048,  99, -2048, -2048};
        vt[5]  = '{    0, 255,     0,     0};
        vt[6]  = '{   -1, 255,  -255,  -255};
        vt[7]  = '{ 1000, 255,  1048,  2047};
        vt[8]  = '{-1000, 255, -1048, -2048};
        vt[9]  = '{ 2047,   1,  2047,  2047};
        vt[10] = '{-2048,   1, -2048, -2048};
        vt[11] = '{   16, 128, -2048,  2047};
        vt[12] = '{  -16, 128, -2048, -2048};
        vt[13] = '{   11, 186,  2046,  2046};

        for (int i = 0; i < 64; i++) rom_tab[i] = 8'(i + 1);
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_coef  = '0;

        // Reset and idle behaviour
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst busy", int'(bus.busy), 0);
        check("rst rom_a", int'(rom_a), 0);
        check("rst out_valid", int'(bus.out_valid), 0);
        check("rst out_coef", int'(bus.out_coef), 0);
        check("rst out_idx", int'(bus.out_idx), 0);
        check("rst blk_done", int'(bus.blk_done), 0);
        step();
        rst = 1'b0;
        clear_caps();
        for (int c = 0; c < 6; c++) begin
            bus.in_valid = c[0] ? 1'b0 : 1'b1;
            bus.in_coef  = 12'(100 + c);
            @(negedge clk);
            check($sformatf("idle busy[%0d]", c), int'(bus.busy), 0);
            check($sformatf("idle rom_a[%0d]", c), int'(rom_a), 0);
            check($sformatf("idle out_valid[%0d]", c), int'(bus.out_valid), 0);
            step();
        end
        bus.in_valid = 1'b0;
        repeat (3) step();
        check("idle no output", cap_idx.size(), 0);

        // Table-driven block: vectors at the head, ramp for the remainder
        load_ramp(2, 0);
        for (int i = 0; i < N_TAB; i++) begin
            stim[i]     = vt[i].coef;
            rom_tab[i]  = 8'(vt[i].q);
            exp_coef[i] = vec_exp(vt[i]);
        end
        clear_caps();
        run_block(0, 64);
        repeat (4) step();
        check_stream("table", 64);

        // Full block, factor i+1, coefficient 2, consecutive
        load_ramp(2, 0);
        clear_caps();
        run_block(0, 64);
        check("full busy after last", int'(bus.busy), 0);
        repeat (4) step();
        check_stream("full", 64);

        // Gapped input: one idle cycle between accepts
        load_ramp(-5, 0);
        clear_caps();
        run_block(1, 64);
        repeat (4) step();
        check_stream("gap", 64);
        for (int i = 1; i < 64 && i < cap_cyc.size(); i++)
            check($sformatf("gap spacing[%0d]", i), cap_cyc[i] - cap_cyc[i-1], 2);

        // Reset after 20 accepts, with start asserted alongside rst
        load_ramp(2, 0);
        clear_caps();
        run_block(0, 20);
        rst          = 1'b1;
        bus.start    = 1'b1;
        bus.in_valid = 1'b1;
        step();
        clear_caps();
        rst          = 1'b0;
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("midrst busy", int'(bus.busy), 0);
        check("midrst rom_a", int'(rom_a), 0);
        check("midrst out_valid", int'(bus.out_valid), 0);
        repeat (4) step();
        check("midrst no output", cap_idx.size(), 0);
        clear_caps();
        run_block(0, 64);
        repeat (4) step();
        check_stream("after rst", 64);

        // Back-to-back blocks: B starts the cycle after busy falls
        load_ramp(2, 0);
        for (int i = 0; i < 64; i++) exp_coef[64 + i] = 3 * (i + 1);
        clear_caps();
        run_block(0, 64);
        for (int i = 0; i < 64; i++) stim[i] = 3;
        run_block(0, 64);
        repeat (4) step();
        check_stream("b2b", 128);
        if (cap_cyc.size() >= 65)
            check("b2b seam spacing", cap_cyc[64] - cap_cyc[63], 2);
        else
            check("b2b seam present", cap_cyc.size(), 128);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
